// File: rtl/l1_rd_port_buf.sv
// Per-port L1 read buffer: derives the L1 pointer for this port's read,
// flags discards and queues {ptr, sid, disc} in a 2-entry in-order FIFO.
module l1_rd_port_buf #(
   parameter int nstrms       = 64,
   parameter int nstrms_width = $clog2(nstrms),
   parameter int nports       = 8,
   parameter int portid       = 0,
   parameter int ptr_width    = 4,
   parameter int cl_size      = 8,
   parameter int clofs_width  = $clog2(cl_size),
   parameter int cnt_width    = 32
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [nstrms-1:0]              i_rst_end,
   input  logic [nstrms-1:0]              i_l1_end,
   input  logic [nstrms-1:0]              i_single_v,
   input  logic                           i_rd_v,
   output logic                           i_rd_r,
   input  logic [nstrms_width-1:0]        i_rd_sid,
   input  logic [nports-1:0]              i_rd_acts,
   input  logic [nports*nstrms_width-1:0] i_rd_sids,
   output logic                           o_rd_act,
   input  logic [nstrms*ptr_width-1:0]    i_ptrs,
   output logic [nstrms-1:0]              o_req_v,
   input  logic [nstrms-1:0]              o_req_r,
   output logic                           o_addr_v,
   input  logic                           o_addr_r,
   output logic [ptr_width-1:0]           o_addr_ptr,
   output logic [nstrms_width-1:0]        o_addr_sid,
   output logic                           o_addr_discard,
   output logic [cnt_width-1:0]           o_cnt_acc,
   output logic [cnt_width-1:0]           o_cnt_disc
);

   typedef struct packed {
      logic [ptr_width-1:0]    ptr;
      logic [nstrms_width-1:0] sid;
      logic                    disc;
   } ent_t;

   localparam logic [ptr_width-1:0] ptr_one = 1;
   localparam logic [cnt_width-1:0] cnt_one = 1;

   logic [1:0]              cnt;
   ent_t                    e0;
   ent_t                    e1;
   ent_t                    new_ent;
   logic [ptr_width-1:0]    ofs;
   logic [ptr_width-1:0]    ptr_base;
   logic [ptr_width-1:0]    ptr_cur;
   logic                    disc;
   logic                    not_full;
   logic                    push;
   logic                    pop;
   logic [nstrms-1:0]       sid_oh;

   // Lower-numbered active ports reading the same stream go first
   always_comb begin
      ofs = '0;
      for (int j = 0; j < nports; j++) begin
         if (j < portid && i_rd_acts[j] &&
             i_rd_sids[j*nstrms_width +: nstrms_width] == i_rd_sid)
            ofs = ofs + ptr_one;
      end
   end

   always_comb begin
      sid_oh = '0;
      sid_oh[i_rd_sid] = 1'b1;
   end

   assign ptr_base = i_ptrs[int'(i_rd_sid)*ptr_width +: ptr_width];
   assign ptr_cur  = ptr_base + ofs;

   // Past the last valid line once the L2 stream ended with one line left
   assign disc = i_l1_end[i_rd_sid] |
                 (i_rst_end[i_rd_sid] & i_single_v[i_rd_sid] &
                  ptr_cur[clofs_width]);

   assign not_full = (cnt != 2'd2);
   assign i_rd_r   = not_full & (disc | o_req_r[i_rd_sid]);
   assign o_rd_act = i_rd_v & i_rd_r;
   assign o_req_v  = (i_rd_v & ~disc & not_full) ? sid_oh : '0;

   assign push = o_rd_act;
   assign pop  = o_addr_v & o_addr_r;

   assign new_ent.ptr  = ptr_cur;
   assign new_ent.sid  = i_rd_sid;
   assign new_ent.disc = disc;

   assign o_addr_v       = (cnt != 2'd0);
   assign o_addr_ptr     = o_addr_v ? e0.ptr : '0;
   assign o_addr_sid     = o_addr_v ? e0.sid : '0;
   assign o_addr_discard = o_addr_v & e0.disc;

   // Unused entries are kept zero so a shift-down never exposes stale data
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt        <= 2'd0;
         e0         <= '0;
         e1         <= '0;
         o_cnt_acc  <= '0;
         o_cnt_disc <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (cnt == 2'd0)
                  e0 <= new_ent;
               else
                  e1 <= new_ent;
               cnt <= cnt + 2'd1;
            end
            2'b01: begin
               e0  <= e1;
               e1  <= '0;
               cnt <= cnt - 2'd1;
            end
            2'b11: begin
               e0 <= new_ent;
            end
            default: begin
            end
         endcase

         if (push && !disc && o_cnt_acc != '1)
            o_cnt_acc <= o_cnt_acc + cnt_one;
         if (push && disc && o_cnt_disc != '1)
            o_cnt_disc <= o_cnt_disc + cnt_one;
      end
   end

endmodule

// File: tb/tb_l1_rd_port_buf.sv
// Directed bench for l1_rd_port_buf: vector table for pointer/discard
// derivation plus sequences for backpressure, ordering, reset, saturation.
module tb_l1_rd_port_buf;

   localparam int NS = 64;
   localparam int SW = 6;
   localparam int NP = 8;
   localparam int PW = 4;
   localparam int CW = 4;
   localparam int CMAX = 15;

   logic           clk;
   logic           reset;
   logic [NS-1:0]  rst_end;
   logic [NS-1:0]  l1_end;
   logic [NS-1:0]  single_v;
   logic           rd_v;
   logic           rd_r;
   logic [SW-1:0]  rd_sid;
   logic [NP-1:0]  rd_acts;
   logic [NP*SW-1:0] rd_sids;
   logic           rd_act;
   logic [NS*PW-1:0] ptrs;
   logic [NS-1:0]  req_v;
   logic [NS-1:0]  req_r;
   logic           addr_v;
   logic           addr_r;
   logic [PW-1:0]  addr_ptr;
   logic [SW-1:0]  addr_sid;
   logic           addr_disc;
   logic [CW-1:0]  cnt_acc;
   logic [CW-1:0]  cnt_disc;

   int n_err = 0;
   int n_chk = 0;
   int exp_acc = 0;
   int exp_disc = 0;

   l1_rd_port_buf #(
      .nstrms(NS), .nports(NP), .portid(2), .ptr_width(PW),
      .cl_size(8), .cnt_width(CW)
   ) dut (
      .clk(clk), .reset(reset),
      .i_rst_end(rst_end), .i_l1_end(l1_end), .i_single_v(single_v),
      .i_rd_v(rd_v), .i_rd_r(rd_r), .i_rd_sid(rd_sid),
      .i_rd_acts(rd_acts), .i_rd_sids(rd_sids), .o_rd_act(rd_act),
      .i_ptrs(ptrs), .o_req_v(req_v), .o_req_r(req_r),
      .o_addr_v(addr_v), .o_addr_r(addr_r), .o_addr_ptr(addr_ptr),
      .o_addr_sid(addr_sid), .o_addr_discard(addr_disc),
      .o_cnt_acc(cnt_acc), .o_cnt_disc(cnt_disc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [SW-1:0] sid;
      logic [NP-1:0] acts;
      logic [SW-1:0] s0;
      logic [SW-1:0] s1;
      logic [SW-1:0] srest;
      logic [PW-1:0] base;
      logic          l1;
      logic          rend;
      logic          sgl;
      logic          rr;
      logic          x_rdr;
      logic          x_reqv;
      logic [PW-1:0] x_ptr;
      logic          x_disc;
   } vec_t;

   vec_t vt[10];

   function automatic vec_t mk(
      input int sid, input int acts, input int s0, input int s1,
      input int srest, input int base, input bit l1, input bit rend,
      input bit sgl, input bit rr, input bit x_rdr, input bit x_reqv,
      input int x_ptr, input bit x_disc);
      vec_t v;
      v.sid = SW'(sid);     v.acts = NP'(acts);
      v.s0 = SW'(s0);       v.s1 = SW'(s1);
      v.srest = SW'(srest); v.base = PW'(base);
      v.l1 = l1;   v.rend = rend; v.sgl = sgl; v.rr = rr;
      v.x_rdr = x_rdr;  v.x_reqv = x_reqv;
      v.x_ptr = PW'(x_ptr); v.x_disc = x_disc;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   function automatic logic [63:0] oh(input int sid);
      logic [63:0] r;
      r = '0;
      r[sid] = 1'b1;
      return r;
   endfunction

   task automatic model_push(input bit d);
      if (d) begin
         if (exp_disc < CMAX) exp_disc++;
      end else begin
         if (exp_acc < CMAX) exp_acc++;
      end
   endtask

   task automatic apply_vec(input vec_t v);
      ptrs = {8{32'hA5C396E1}};
      ptrs[int'(v.sid)*PW +: PW] = v.base;
      l1_end = '1;   l1_end[v.sid] = v.l1;
      rst_end = '1;  rst_end[v.sid] = v.rend;
      single_v = '1; single_v[v.sid] = v.sgl;
      req_r = '0;    req_r[v.sid] = v.rr;
      rd_acts = v.acts;
      for (int j = 0; j < NP; j++)
         rd_sids[j*SW +: SW] = (j == 0) ? v.s0 : (j == 1) ? v.s1 : v.srest;
      rd_sid = v.sid;
   endtask

   task automatic quiet_streams();
      l1_end = '0;
      rst_end = '0;
      single_v = '0;
      rd_acts = '0;
      rd_sids = '0;
      req_r = '0;
   endtask

   initial begin
      vt[0] = mk( 5, 'h03, 5,  5, 5,  3, 0,0,0,1, 1,1,  5, 0);
      vt[1] = mk( 5, 'h01, 5,  5, 5,  3, 0,0,0,1, 1,1,  4, 0);
      vt[2] = mk( 5, 'h03, 5,  6, 5,  3, 0,0,0,1, 1,1,  4, 0);
      vt[3] = mk( 5, 'hFC, 5,  5, 5,  3, 0,0,0,1, 1,1,  3, 0);
      vt[4] = mk( 9, 'h03, 9,  9, 0, 15, 0,0,0,1, 1,1,  1, 0);
      vt[5] = mk( 7, 'h03, 1,  2, 7,  0, 1,0,0,0, 1,0,  0, 1);
      vt[6] = mk( 3, 'h01, 3,  0, 3,  7, 0,1,1,0, 1,0,  8, 1);
      vt[7] = mk( 3, 'h00, 3,  3, 3,  7, 0,1,1,1, 1,1,  7, 0);
      vt[8] = mk( 3, 'h00, 3,  3, 3,  8, 0,1,0,1, 1,1,  8, 0);
      vt[9] = mk(63, 'h02, 0, 63, 0, 12, 0,0,0,1, 1,1, 13, 0);

      reset = 1'b1;
      rd_v = 1'b0;
      addr_r = 1'b0;
      rd_sid = '0;
      ptrs = '0;
      quiet_streams();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_addr_v", addr_v, 0);
      chk("rst_addr_ptr", addr_ptr, 0);
      chk("rst_cnt_acc", cnt_acc, 0);
      chk("rst_cnt_disc", cnt_disc, 0);
      chk("rst_req_v", req_v, 0);

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         apply_vec(vt[i]);
         rd_v = 1'b1;
         addr_r = 1'b0;
         #1;
         chk($sformatf("v%0d_rd_r", i), rd_r, vt[i].x_rdr);
         chk($sformatf("v%0d_rd_act", i), rd_act, vt[i].x_rdr);
         chk($sformatf("v%0d_req_v", i), req_v,
             vt[i].x_reqv ? oh(int'(vt[i].sid)) : 64'd0);
         @(posedge clk);
         #1;
         if (vt[i].x_rdr) model_push(vt[i].x_disc);
         chk($sformatf("v%0d_addr_v", i), addr_v, 1);
         chk($sformatf("v%0d_ptr", i), addr_ptr, vt[i].x_ptr);
         chk($sformatf("v%0d_sid", i), addr_sid, vt[i].sid);
         chk($sformatf("v%0d_disc", i), addr_disc, vt[i].x_disc);
         chk($sformatf("v%0d_cnt_acc", i), cnt_acc, exp_acc);
         chk($sformatf("v%0d_cnt_disc", i), cnt_disc, exp_disc);
         @(negedge clk);
         rd_v = 1'b0;
         addr_r = 1'b1;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_drained", i), addr_v, 0);
      end

      // Backpressure: two reads fill the FIFO, the third is refused
      @(negedge clk);
      quiet_streams();
      ptrs = '0;
      req_r[1] = 1'b1;
      rd_sid = 6'd1;
      addr_r = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         ptrs[1*PW +: PW] = PW'(2 + 2*k);
         rd_v = 1'b1;
         #1;
         if (k < 2) begin
            chk($sformatf("bp%0d_rd_r", k), rd_r, 1);
         end else begin
            chk("bp_full_rd_r", rd_r, 0);
            chk("bp_full_rd_act", rd_act, 0);
            chk("bp_full_req_v", req_v, 0);
         end
         @(posedge clk);
         #1;
         if (k < 2) model_push(1'b0);
         chk($sformatf("bp%0d_head_ptr", k), addr_ptr, 2);
         chk($sformatf("bp%0d_head_sid", k), addr_sid, 1);
      end
      @(negedge clk);
      rd_v = 1'b0;
      addr_r = 1'b1;
      #1;
      chk("bp_drain0_v", addr_v, 1);
      chk("bp_drain0_ptr", addr_ptr, 2);
      @(posedge clk);
      #1;
      chk("bp_drain1_v", addr_v, 1);
      chk("bp_drain1_ptr", addr_ptr, 4);
      @(posedge clk);
      #1;
      chk("bp_empty_v", addr_v, 0);
      chk("bp_empty_ptr", addr_ptr, 0);
      chk("bp_empty_sid", addr_sid, 0);
      chk("bp_cnt_acc", cnt_acc, exp_acc);

      // Pointer-update not ready: request still raised, nothing pushed
      @(negedge clk);
      quiet_streams();
      rd_sid = 6'd4;
      ptrs[4*PW +: PW] = 4'd5;
      rd_v = 1'b1;
      addr_r = 1'b0;
      #1;
      chk("nr_rd_r", rd_r, 0);
      chk("nr_rd_act", rd_act, 0);
      chk("nr_req_v", req_v, oh(4));
      @(posedge clk);
      #1;
      chk("nr_addr_v", addr_v, 0);
      chk("nr_cnt_acc", cnt_acc, exp_acc);

      // Simultaneous push and pop keeps one entry, newest at head
      @(negedge clk);
      rd_sid = 6'd2;
      req_r[2] = 1'b1;
      ptrs[2*PW +: PW] = 4'd6;
      rd_v = 1'b1;
      addr_r = 1'b0;
      @(posedge clk);
      #1;
      model_push(1'b0);
      chk("pp_first_ptr", addr_ptr, 6);
      @(negedge clk);
      ptrs[2*PW +: PW] = 4'd9;
      addr_r = 1'b1;
      #1;
      chk("pp_rd_r", rd_r, 1);
      @(posedge clk);
      #1;
      model_push(1'b0);
      chk("pp_addr_v", addr_v, 1);
      chk("pp_ptr", addr_ptr, 9);
      @(negedge clk);
      rd_v = 1'b0;
      @(posedge clk);
      #1;
      chk("pp_empty", addr_v, 0);
      chk("pp_cnt_acc", cnt_acc, exp_acc);

      // Reset while full and with a push/pop pending
      @(negedge clk);
      addr_r = 1'b0;
      rd_v = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rf_full_rd_r", rd_r, 0);
      @(negedge clk);
      reset = 1'b1;
      addr_r = 1'b1;
      @(posedge clk);
      #1;
      exp_acc = 0;
      exp_disc = 0;
      chk("rf_addr_v", addr_v, 0);
      chk("rf_cnt_acc", cnt_acc, 0);
      chk("rf_cnt_disc", cnt_disc, 0);
      @(negedge clk);
      reset = 1'b0;
      rd_v = 1'b0;
      #1;
      chk("rf_req_v", req_v, 0);
      chk("rf_addr_v2", addr_v, 0);

      // Accepted counter saturates
      @(negedge clk);
      rd_v = 1'b1;
      addr_r = 1'b1;
      repeat (17) begin
         @(posedge clk);
         model_push(1'b0);
      end
      #1;
      rd_v = 1'b0;
      chk("sat_cnt_acc", cnt_acc, exp_acc);
      chk("sat_cnt_disc", cnt_disc, 0);

      // Discard counter saturates too
      @(negedge clk);
      l1_end[2] = 1'b1;
      req_r = '0;
      rd_v = 1'b1;
      repeat (16) begin
         @(posedge clk);
         model_push(1'b1);
      end
      #1;
      rd_v = 1'b0;
      chk("sat_cnt_disc2", cnt_disc, exp_disc);
      chk("sat_cnt_acc2", cnt_acc, exp_acc);

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
